// File: rtl/spi_pkg.sv
// Shared SPI transmitter definitions: FSM states, bus mode and divider default.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HIGH,
        SCK_LOW,
        HOLD,
        DONE,
        GAP
    } spi_state_e;

    // Mode 0: SCLK idles low, data is sampled on the rising edge.
    localparam logic SPI_CPOL    = 1'b0;
    localparam logic SPI_CPHA    = 1'b0;
    localparam int   CLK_DIV_DEF = 4;

    function automatic logic first_bit(input logic [7:0] b, input logic msb_first);
        return msb_first ? b[7] : b[0];
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: reloads to CLK_DIV-1 on every state entry and stops at zero.
// Tick is combinational from the counter register; no backpressure.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_bar,
    input  logic i_load,
    output logic o_tick
);

    localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            r_cnt <= 8'd0;
        end else if (i_load) begin
            r_cnt <= RELOAD;
        end else if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_tick = (r_cnt == 8'd0);

endmodule

// File: rtl/spi_master_tx.sv
// Mode-0 SPI byte transmitter fed by an upstream key buffer; frame starts one clk after d is seen valid.
// Latency: 18*CLK_DIV cycles of cs_n low, ack pulse, then CLK_DIV-cycle gap; upstream waits on transfer_done.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int CLK_DIV   = CLK_DIV_DEF,
    parameter int MSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       rst_bar,
    input  logic [7:0] d,
    input  logic [1:0] status_ctr,
    output logic       transfer_done,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic       tx_active
);

    localparam logic MSB = (MSB_FIRST != 0);

    if (CLK_DIV < 2 || CLK_DIV > 255 || SPI_CPHA != 1'b0) begin : g_param_chk
        $error("spi_master_tx: unsupported CLK_DIV or SPI mode");
    end

    spi_state_e r_state;
    spi_state_e w_state_nxt;
    logic [7:0] r_sr;
    logic [2:0] r_bit_cnt;
    logic       r_last;
    logic [1:0] r_rst_sync;
    logic       r_cs_n;
    logic       r_sclk;
    logic       r_mosi;
    logic       r_done;
    logic       r_active;
    logic       w_tick;
    logic       w_load;
    logic       w_latch;
    logic       w_shift;
    logic       w_cs_lo;
    logic [7:0] w_sr_shift;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk     (clk),
        .rst_bar (rst_bar),
        .i_load  (w_load),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // r_last marks that the eighth bit has been shifted out, so the low phase after it closes the frame.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_rst_sync[1] && status_ctr != 2'd0) begin
                    w_state_nxt = SETUP;
                    w_latch     = 1'b1;
                end
            end
            SETUP:    if (w_tick) w_state_nxt = SCK_HIGH;
            SCK_HIGH: begin
                if (w_tick) begin
                    w_state_nxt = SCK_LOW;
                    w_shift     = 1'b1;
                end
            end
            SCK_LOW:  if (w_tick) w_state_nxt = r_last ? HOLD : SCK_HIGH;
            HOLD:     if (w_tick) w_state_nxt = DONE;
            DONE:     w_state_nxt = GAP;
            GAP:      if (w_tick) w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    assign w_load     = (w_state_nxt != r_state);
    assign w_sr_shift = MSB ? {r_sr[6:0], 1'b0} : {1'b0, r_sr[7:1]};
    assign w_cs_lo    = (w_state_nxt == SETUP) || (w_state_nxt == SCK_HIGH) ||
                        (w_state_nxt == SCK_LOW) || (w_state_nxt == HOLD);

    // Outputs are registered from the next state so they line up with r_state without a decode stage.
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            r_sr       <= 8'd0;
            r_bit_cnt  <= 3'd0;
            r_last     <= 1'b0;
            r_rst_sync <= 2'b00;
            r_cs_n     <= 1'b1;
            r_sclk     <= SPI_CPOL;
            r_mosi     <= 1'b0;
            r_done     <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
            r_cs_n     <= ~w_cs_lo;
            r_sclk     <= SPI_CPOL ^ (w_state_nxt == SCK_HIGH);
            r_done     <= (w_state_nxt == DONE);
            r_active   <= (w_state_nxt != IDLE);
            if (w_latch) begin
                r_sr      <= d;
                r_mosi    <= first_bit(d, MSB);
                r_bit_cnt <= 3'd0;
                r_last    <= 1'b0;
            end else if (w_shift) begin
                r_sr      <= w_sr_shift;
                r_mosi    <= first_bit(w_sr_shift, MSB);
                r_bit_cnt <= r_bit_cnt + 3'd1;
                if (r_bit_cnt == 3'd7) begin
                    r_last <= 1'b1;
                end
            end
        end
    end

    assign transfer_done = r_done;
    assign sclk          = r_sclk;
    assign mosi          = r_mosi;
    assign cs_n          = r_cs_n;
    assign tx_active     = r_active;

endmodule

// File: tb/tb_spi_master_tx.sv
// Two transmitters (CLK_DIV=4 MSB-first, CLK_DIV=2 LSB-first) observed as SPI slaves and compared to a frame model.
module tb_spi_master_tx;

    localparam int CA = 4;
    localparam int CB = 2;

    typedef struct {
        logic [7:0] bits;
        int         low;
        int         edges;
        int         td_first;
        int         pmin;
        int         pmax;
        int         t_start;
        int         t_end;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst_bar;
    logic [7:0] d_a, d_b;
    logic [1:0] st_a, st_b;
    logic [1:0] sclk_o, mosi_o, cs_o, td_o, act_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    frame_t     fq0[$];
    frame_t     fq1[$];
    int         low_c[2], edg[2], pmin[2], pmax[2], last_rise[2], t_start[2], td_tot[2], viol[2];
    logic [7:0] rx[2];
    logic       prev_cs[2], prev_sclk[2];

    spi_master_tx #(.CLK_DIV(CA), .MSB_FIRST(1)) u_a (
        .clk(clk), .rst_bar(rst_bar), .d(d_a), .status_ctr(st_a),
        .transfer_done(td_o[0]), .sclk(sclk_o[0]), .mosi(mosi_o[0]),
        .cs_n(cs_o[0]), .tx_active(act_o[0])
    );

    spi_master_tx #(.CLK_DIV(CB), .MSB_FIRST(0)) u_b (
        .clk(clk), .rst_bar(rst_bar), .d(d_b), .status_ctr(st_b),
        .transfer_done(td_o[1]), .sclk(sclk_o[1]), .mosi(mosi_o[1]),
        .cs_n(cs_o[1]), .tx_active(act_o[1])
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycles=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Position 7-k holds the k-th bit on the wire, matching how the slave monitor shifts bits in.
    function automatic logic [7:0] wire_order(input logic [7:0] b, input bit msb);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[7-k] = msb ? b[7-k] : b[k];
        return r;
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? fq0.size() : fq1.size();
    endfunction

    function automatic frame_t qget(input int i, input int n);
        frame_t f;
        f = '{default: 0};
        if (i == 0 && n >= 0 && n < fq0.size()) f = fq0[n];
        if (i == 1 && n >= 0 && n < fq1.size()) f = fq1[n];
        return f;
    endfunction

    // SPI slave view of one DUT, sampled on the falling clk edge.
    task automatic mon(input int i);
        frame_t f;
        if (!cs_o[i]) low_c[i]++;
        if (!cs_o[i] && prev_cs[i]) t_start[i] = cyc;
        if (sclk_o[i] && !prev_sclk[i]) begin
            if (edg[i] > 0) begin
                if (cyc - last_rise[i] < pmin[i]) pmin[i] = cyc - last_rise[i];
                if (cyc - last_rise[i] > pmax[i]) pmax[i] = cyc - last_rise[i];
            end
            last_rise[i] = cyc;
            edg[i]++;
            rx[i] = {rx[i][6:0], mosi_o[i]};
        end
        if (!cs_o[i] && !act_o[i]) viol[i]++;
        if (sclk_o[i] && cs_o[i]) viol[i]++;
        if (td_o[i]) td_tot[i]++;
        if (td_o[i] && !(cs_o[i] && !prev_cs[i])) viol[i]++;
        if (cs_o[i] && !prev_cs[i]) begin
            f.bits = rx[i]; f.low = low_c[i]; f.edges = edg[i]; f.td_first = int'(td_o[i]);
            f.pmin = pmin[i]; f.pmax = pmax[i]; f.t_start = t_start[i]; f.t_end = cyc;
            if (i == 0) fq0.push_back(f); else fq1.push_back(f);
            low_c[i] = 0; edg[i] = 0; pmin[i] = 1000000; pmax[i] = 0;
        end
        prev_cs[i]   = cs_o[i];
        prev_sclk[i] = sclk_o[i];
    endtask

    always @(negedge clk) begin
        cyc++;
        mon(0);
        mon(1);
    end

    task automatic drive(input int i, input logic [7:0] b, input logic [1:0] s);
        if (i == 0) begin d_a = b; st_a = s; end
        else begin d_b = b; st_b = s; end
    endtask

    task automatic check_frame(input int i, input int n, input logic [7:0] b, input string tag);
        frame_t f;
        int     c;
        c = (i == 0) ? CA : CB;
        f = qget(i, n);
        chk({tag, "_byte"}, f.bits, wire_order(b, i == 0));
        chk({tag, "_cs_low"}, f.low, 18 * c);
        chk({tag, "_edges"}, f.edges, 8);
        chk({tag, "_done_at_cs_rise"}, f.td_first, 1);
        chk({tag, "_sclk_pmin"}, f.pmin, 2 * c);
        chk({tag, "_sclk_pmax"}, f.pmax, 2 * c);
    endtask

    // One frame: present b with a random nonzero fill count, drop it once accepted, optionally disturb d mid-frame.
    task automatic send(input int i, input logic [7:0] b, input int chg_edge, input logic [7:0] chg_val,
                        input string tag);
        int n0;
        int c;
        c  = (i == 0) ? CA : CB;
        n0 = qsize(i);
        drive(i, b, 2'($urandom_range(1, 3)));
        for (int k = 0; k < 50 && act_o[i] !== 1'b1; k++) @(negedge clk);
        chk({tag, "_start"}, act_o[i], 1);
        drive(i, b, 2'd0);
        if (chg_edge > 0) begin
            for (int k = 0; k < 40 * c && edg[i] < chg_edge; k++) @(negedge clk);
            chk({tag, "_edge_seen"}, edg[i] >= chg_edge, 1);
            drive(i, chg_val, 2'($urandom_range(1, 3)));
        end
        for (int k = 0; k < 40 * c && qsize(i) == n0; k++) @(negedge clk);
        chk({tag, "_end"}, qsize(i), n0 + 1);
        drive(i, (i == 0) ? d_a : d_b, 2'd0);
        check_frame(i, n0, b, tag);
        repeat (4 * c) @(negedge clk);
    endtask

    initial begin
        logic [7:0] b;
        int         n0;
        int         td0;
        frame_t     f0, f1;

        for (int i = 0; i < 2; i++) begin
            low_c[i] = 0; edg[i] = 0; pmin[i] = 1000000; pmax[i] = 0; last_rise[i] = 0;
            t_start[i] = 0; td_tot[i] = 0; viol[i] = 0; rx[i] = 8'h00;
            prev_cs[i] = 1'b1; prev_sclk[i] = 1'b0;
        end
        rst_bar = 1'b0;
        d_a = 8'h00; d_b = 8'h00; st_a = 2'd0; st_b = 2'd0;

        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_o, 2'b11);
        chk("rst_sclk", sclk_o, 2'b00);
        chk("rst_mosi", mosi_o, 2'b00);
        chk("rst_done", td_o, 2'b00);
        chk("rst_active", act_o, 2'b00);

        rst_bar = 1'b1;
        repeat (200) @(negedge clk);
        chk("idle_frames_a", qsize(0), 0);
        chk("idle_frames_b", qsize(1), 0);
        chk("idle_cs_low", low_c[0] + low_c[1], 0);
        chk("idle_done", td_tot[0] + td_tot[1], 0);
        chk("idle_cs_n", cs_o, 2'b11);
        chk("idle_sclk", sclk_o, 2'b00);

        send(0, 8'h05, 0, 8'h00, "a_05");
        send(1, 8'h05, 0, 8'h00, "b_05");
        for (int t = 0; t < 5; t++) send(0, 8'($urandom), 0, 8'h00, "a_rnd");
        for (int t = 0; t < 5; t++) send(1, 8'($urandom), 0, 8'h00, "b_rnd");

        send(0, 8'h0A, 3, 8'h0F, "a_dchg");
        send(1, 8'($urandom), 3, 8'($urandom), "b_dchg");

        // Back-to-back: fill count held at 2, upstream advances d on each ack.
        n0  = qsize(0);
        td0 = td_tot[0];
        d_a = 8'h03; st_a = 2'd2;
        for (int k = 0; k < 200 && td_o[0] !== 1'b1; k++) @(negedge clk);
        chk("b2b_ack1", td_o[0], 1);
        d_a = 8'h09;
        @(negedge clk);
        for (int k = 0; k < 200 && td_o[0] !== 1'b1; k++) @(negedge clk);
        chk("b2b_ack2", td_o[0], 1);
        st_a = 2'd0;
        repeat (40) @(negedge clk);
        chk("b2b_frames", qsize(0), n0 + 2);
        check_frame(0, n0, 8'h03, "b2b_f1");
        check_frame(0, n0 + 1, 8'h09, "b2b_f2");
        f0 = qget(0, n0);
        f1 = qget(0, n0 + 1);
        chk("b2b_gap_min", (f1.t_start - f0.t_end) >= 4, 1);
        chk("b2b_spacing", f1.t_start - f0.t_start, 19 * CA + 2);
        chk("b2b_done_cnt", td_tot[0] - td0, 2);

        // Reset at the 5th rising SCLK edge aborts the frame; the pending byte is resent after release.
        b   = 8'($urandom);
        n0  = qsize(0);
        td0 = td_tot[0];
        d_a = b; st_a = 2'd1;
        for (int k = 0; k < 50 && act_o[0] !== 1'b1; k++) @(negedge clk);
        chk("rst_mid_start", act_o[0], 1);
        for (int k = 0; k < 100 && edg[0] < 5; k++) @(negedge clk);
        chk("rst_mid_edge5", edg[0], 5);
        #1 rst_bar = 1'b0;
        #1;
        chk("rst_mid_cs_n", cs_o[0], 1);
        chk("rst_mid_sclk", sclk_o[0], 0);
        chk("rst_mid_mosi", mosi_o[0], 0);
        chk("rst_mid_active", act_o[0], 0);
        chk("rst_mid_done", td_o[0], 0);
        repeat (3) @(negedge clk);
        rst_bar = 1'b1;
        chk("rst_abort_logged", qsize(0), n0 + 1);
        f0 = qget(0, n0);
        chk("rst_abort_edges", f0.edges, 5);
        chk("rst_abort_no_done", f0.td_first, 0);
        for (int k = 0; k < 20 && act_o[0] !== 1'b1; k++) @(negedge clk);
        chk("rst_resend_start", act_o[0], 1);
        st_a = 2'd0;
        for (int k = 0; k < 200 && qsize(0) < n0 + 2; k++) @(negedge clk);
        chk("rst_resend_end", qsize(0), n0 + 2);
        check_frame(0, n0 + 1, b, "rst_resend");
        chk("rst_done_cnt", td_tot[0] - td0, 1);

        repeat (20) @(negedge clk);
        chk("proto_viol_a", viol[0], 0);
        chk("proto_viol_b", viol[1], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
